// File: rtl/serial_alu_pkg.sv
// Shared opcodes, sequencer state encoding and mode validation for the bit-serial ALU.
package serial_alu_pkg;

    localparam logic [2:0] MODE_ADD  = 3'b000;
    localparam logic [2:0] MODE_AND  = 3'b001;
    localparam logic [2:0] MODE_OR   = 3'b010;
    localparam logic [2:0] MODE_XOR  = 3'b011;
    localparam logic [2:0] MODE_XNOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic mode_is_valid(input logic [2:0] mode);
        return mode <= MODE_XNOR;
    endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Request/result bundle between the control logic and the serial ALU sequencer.
// Zero exists only when SERIAL_ALU_ZERO_FLAG_EN is defined.
interface serial_alu_seq_if #(parameter int WIDTH = 8);
    logic             Start;
    logic [2:0]       Mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] X;
    logic             C_out;
    logic             Err;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             Zero;

    modport master (output Start, Mode, A, B, C_in, input Busy, Done, X, C_out, Err, Zero);
    modport slave  (input Start, Mode, A, B, C_in, output Busy, Done, X, C_out, Err, Zero);
`else
    modport master (output Start, Mode, A, B, C_in, input Busy, Done, X, C_out, Err);
    modport slave  (input Start, Mode, A, B, C_in, output Busy, Done, X, C_out, Err);
`endif
endinterface

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice; carry out is meaningful only for ADD.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    output logic       x,
    output logic       c_out
);
    always_comb begin
        x     = 1'b0;
        c_out = 1'b0;
        case (mode)
            MODE_ADD: begin
                x     = a ^ b ^ c_in;
                c_out = (a & b) | (c_in & (a ^ b));
            end
            MODE_AND:  x = a & b;
            MODE_OR:   x = a | b;
            MODE_XOR:  x = a ^ b;
            MODE_XNOR: x = ~(a ^ b);
            default:   x = 1'b0;
        endcase
    end
endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer: runs one ALU slice over WIDTH cycles, LSB first, to build a full word.
// Optional Zero flag enabled by SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic            CLK,
    input logic            RST_N,
    serial_alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, x_sh, x_r;
    logic [2:0]       mode_r;
    logic [CW-1:0]    cnt;
    logic             carry, c_out_r, err_r;
    logic             sl_x, sl_c;
    logic             accept, last_bit;

    serial_alu_slice u_slice (
        .mode  (mode_r),
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .x     (sl_x),
        .c_out (sl_c)
    );

    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && bus.Start;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) state_nxt = mode_is_valid(bus.Mode) ? ST_RUN : ST_DONE;
                else           state_nxt = ST_IDLE;
            end
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Visible results move only at Start acceptance and DONE entry; x_sh holds the partial word.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_sh    <= '0;
            b_sh    <= '0;
            x_sh    <= '0;
            x_r     <= '0;
            mode_r  <= MODE_ADD;
            cnt     <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.A;
            b_sh    <= bus.B;
            mode_r  <= bus.Mode;
            cnt     <= '0;
            x_r     <= '0;
            c_out_r <= 1'b0;
            err_r   <= !mode_is_valid(bus.Mode);
            carry   <= (bus.Mode == MODE_ADD) ? bus.C_in : 1'b0;
        end else if (state == ST_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            x_sh <= {sl_x, x_sh[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
            if (mode_r == MODE_ADD) carry <= sl_c;
            if (last_bit) begin
                x_r     <= {sl_x, x_sh[WIDTH-1:1]};
                c_out_r <= (mode_r == MODE_ADD) ? sl_c : 1'b0;
            end
        end
    end

`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic zero_acc, zero_r;

    // Running AND of inverted result bits; a reserved mode reports Zero=1 immediately.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            zero_acc <= 1'b0;
            zero_r   <= 1'b0;
        end else if (accept) begin
            zero_acc <= 1'b1;
            zero_r   <= !mode_is_valid(bus.Mode);
        end else if (state == ST_RUN) begin
            zero_acc <= zero_acc & ~sl_x;
            if (last_bit) zero_r <= zero_acc & ~sl_x;
        end
    end

    assign bus.Zero = zero_r;
`endif

    assign bus.Busy  = (state == ST_RUN);
    assign bus.Done  = (state == ST_DONE);
    assign bus.X     = x_r;
    assign bus.C_out = c_out_r;
    assign bus.Err   = err_r;

endmodule
